// File: rtl/laser_sync_controller.sv
// Laser/digitizer timing controller: periodic laser trigger plus a delayed digitizer trigger
// qualified by encoder-referenced gate windows, with burst limiting and overrun flags.
module laser_sync_controller #(
  parameter int CNT_W     = 32,
  parameter int NUM_GATES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       encoder_trigger,
  input  logic                       clear_status,
  input  logic [CNT_W-1:0]           period,
  input  logic [CNT_W-1:0]           laser_width,
  input  logic [CNT_W-1:0]           dig_delay,
  input  logic [CNT_W-1:0]           dig_width,
  input  logic [NUM_GATES*CNT_W-1:0] gate_delay,
  input  logic [CNT_W-1:0]           gate_len,
  input  logic [CNT_W-1:0]           burst_limit,
  output logic                       laser_trigger,
  output logic                       digitizer_trigger,
  output logic                       gate_active,
  output logic [CNT_W-1:0]           dig_count,
  output logic [NUM_GATES-1:0]       gate_overrun,
  output logic                       delay_overrun
);

  typedef enum logic [1:0] {G_IDLE, G_DELAY, G_OPEN} gate_state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0]     r_cnt, r_per, r_laser_rem, r_dly_cnt, r_dig_rem, r_bcnt, r_dig_count;
  logic                 r_dly_pend, r_dly_ovr, r_gate_prev;
  logic [NUM_GATES-1:0] r_gate_ovr;
  gate_state_t          r_gstate [NUM_GATES];
  logic [CNT_W-1:0]     r_gcnt   [NUM_GATES];

  logic [CNT_W-1:0]     w_per, w_bcnt_eff;
  logic [NUM_GATES-1:0] w_open;
  logic                 w_tick, w_cand, w_gate_any, w_rise, w_accept;

  // The period is latched whenever the counter sits at 0, so it only changes at a period start.
  assign w_per  = (period < TWO) ? TWO : period;
  assign w_tick = enable && (r_cnt == r_per - ONE);

  // A tick landing on the expiry cycle of a pending delay drops that candidate.
  assign w_cand = (w_tick && (dig_delay == '0)) ||
                  (r_dly_pend && (r_dly_cnt == ONE) && !w_tick);

  always_comb begin
    w_open = '0;
    for (int i = 0; i < NUM_GATES; i++) w_open[i] = (r_gstate[i] == G_OPEN);
  end

  assign w_gate_any = |w_open;
  assign w_rise     = w_gate_any && !r_gate_prev;
  assign w_bcnt_eff = w_rise ? '0 : r_bcnt;
  assign w_accept   = w_cand && w_gate_any &&
                      ((burst_limit == '0) || (w_bcnt_eff < burst_limit));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_per       <= '0;
      r_laser_rem <= '0;
      r_dly_cnt   <= '0;
      r_dly_pend  <= 1'b0;
      r_dly_ovr   <= 1'b0;
    end else begin
      if (!enable || w_tick) r_cnt <= '0;
      else                   r_cnt <= r_cnt + ONE;
      if (r_cnt == '0) r_per <= w_per;

      if (w_tick)                  r_laser_rem <= laser_width;
      else if (r_laser_rem != '0)  r_laser_rem <= r_laser_rem - ONE;

      if (w_tick) begin
        r_dly_cnt  <= dig_delay;
        r_dly_pend <= (dig_delay != '0);
      end else if (r_dly_pend) begin
        r_dly_cnt <= r_dly_cnt - ONE;
        if (r_dly_cnt == ONE) r_dly_pend <= 1'b0;
      end

      if (clear_status)              r_dly_ovr <= 1'b0;
      else if (w_tick && r_dly_pend) r_dly_ovr <= 1'b1;
    end
  end

  // Gate channels all see the same encoder pulse; a busy channel ignores it and flags overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_GATES; i++) begin
        r_gstate[i] <= G_IDLE;
        r_gcnt[i]   <= '0;
      end
      r_gate_ovr <= '0;
    end else begin
      for (int i = 0; i < NUM_GATES; i++) begin
        case (r_gstate[i])
          G_IDLE: begin
            if (encoder_trigger) begin
              if (gate_delay[i*CNT_W +: CNT_W] != '0) begin
                r_gstate[i] <= G_DELAY;
                r_gcnt[i]   <= gate_delay[i*CNT_W +: CNT_W];
              end else if (gate_len != '0) begin
                r_gstate[i] <= G_OPEN;
                r_gcnt[i]   <= gate_len;
              end
            end
          end
          G_DELAY: begin
            if (r_gcnt[i] == ONE) begin
              r_gstate[i] <= (gate_len != '0) ? G_OPEN : G_IDLE;
              r_gcnt[i]   <= gate_len;
            end else begin
              r_gcnt[i] <= r_gcnt[i] - ONE;
            end
          end
          G_OPEN: begin
            if (r_gcnt[i] == ONE) r_gstate[i] <= G_IDLE;
            else                  r_gcnt[i]   <= r_gcnt[i] - ONE;
          end
          default: r_gstate[i] <= G_IDLE;
        endcase
        if (clear_status)
          r_gate_ovr[i] <= 1'b0;
        else if (encoder_trigger && (r_gstate[i] != G_IDLE))
          r_gate_ovr[i] <= 1'b1;
      end
    end
  end

  // Overlapping channel windows merge into one burst window via the OR'd gate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gate_prev <= 1'b0;
      r_bcnt      <= '0;
      r_dig_rem   <= '0;
      r_dig_count <= '0;
    end else begin
      r_gate_prev <= w_gate_any;
      r_bcnt      <= w_accept ? (w_bcnt_eff + ONE) : w_bcnt_eff;

      if (w_accept)              r_dig_rem <= dig_width;
      else if (r_dig_rem != '0)  r_dig_rem <= r_dig_rem - ONE;

      if (clear_status)  r_dig_count <= '0;
      else if (w_accept) r_dig_count <= r_dig_count + ONE;
    end
  end

  assign laser_trigger     = (r_laser_rem != '0);
  assign digitizer_trigger = (r_dig_rem != '0);
  assign gate_active       = w_gate_any;
  assign dig_count         = r_dig_count;
  assign gate_overrun      = r_gate_ovr;
  assign delay_overrun     = r_dly_ovr;

endmodule

// File: tb/tb_laser_sync_controller.sv
// Self-checking bench for laser_sync_controller: directed and random scenarios compared
// cycle by cycle against an interval-based reference model.
module tb_laser_sync_controller;

  localparam int CNT_W = 32;
  localparam int NG    = 4;
  localparam int MAXC  = 512;
  localparam int NCYC  = 300;

  logic                  clk = 1'b0;
  logic                  reset, enable, encoder_trigger, clear_status;
  logic [CNT_W-1:0]      period, laser_width, dig_delay, dig_width, gate_len, burst_limit;
  logic [NG*CNT_W-1:0]   gate_delay;
  logic                  laser_trigger, digitizer_trigger, gate_active, delay_overrun;
  logic [CNT_W-1:0]      dig_count;
  logic [NG-1:0]         gate_overrun;

  laser_sync_controller #(.CNT_W(CNT_W), .NUM_GATES(NG)) dut (
    .clk(clk), .reset(reset), .enable(enable), .encoder_trigger(encoder_trigger),
    .clear_status(clear_status), .period(period), .laser_width(laser_width),
    .dig_delay(dig_delay), .dig_width(dig_width), .gate_delay(gate_delay),
    .gate_len(gate_len), .burst_limit(burst_limit), .laser_trigger(laser_trigger),
    .digitizer_trigger(digitizer_trigger), .gate_active(gate_active),
    .dig_count(dig_count), .gate_overrun(gate_overrun), .delay_overrun(delay_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int scen   = 0;

  int cfgPeriodRaw, cfgP, cfgLw, cfgDd, cfgDw, cfgGl, cfgBl, cfgT0;
  int cfgGd [NG];

  bit               encA [MAXC];
  bit               clrA [MAXC];
  bit               laserA [MAXC];
  bit               candA [MAXC];
  bit               gateA [MAXC];
  bit               accA [MAXC];
  bit               digA [MAXC];
  bit               dovEv [MAXC];
  bit [NG-1:0]      govEv [MAXC];
  logic [CNT_W-1:0] expCount [MAXC];
  bit [NG-1:0]      expGov [MAXC];
  bit               expDov [MAXC];

  task automatic checkOutput(input string tag, input int cyc,
                             input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s scen=%0d cyc=%0d observed=%0h expected=%0h", tag, scen, cyc, obs, exp);
    end
  endtask

  task automatic setConfig(input int pr, input int lw, input int dd, input int dw,
                           input int gl, input int bl, input int t0,
                           input int g0, input int g1, input int g2, input int g3);
    cfgPeriodRaw = pr;
    cfgP  = (pr < 2) ? 2 : pr;
    cfgLw = lw; cfgDd = dd; cfgDw = dw; cfgGl = gl; cfgBl = bl; cfgT0 = t0;
    cfgGd[0] = g0; cfgGd[1] = g1; cfgGd[2] = g2; cfgGd[3] = g3;
  endtask

  task automatic clearStim();
    for (int c = 0; c < MAXC; c++) begin
      encA[c] = 1'b0;
      clrA[c] = 1'b0;
    end
  endtask

  // Reference model: event times and windows derived as intervals, then sticky/cumulative state.
  task automatic buildModel();
    int prev, busyEnd, bc;
    bit prevG;
    logic [CNT_W-1:0] cnt;
    bit [NG-1:0] gov;
    bit dov;
    for (int c = 0; c < MAXC; c++) begin
      laserA[c] = 0; candA[c] = 0; gateA[c] = 0; accA[c] = 0;
      digA[c] = 0; dovEv[c] = 0; govEv[c] = '0;
    end
    prev = -1;
    for (int t = cfgT0 + cfgP - 1; t < MAXC; t += cfgP) begin
      for (int k = 1; k <= cfgLw; k++) if (t + k < MAXC) laserA[t+k] = 1;
      if (cfgDd == 0) candA[t] = 1;
      else if ((t + cfgP > t + cfgDd) && (t + cfgDd < MAXC)) candA[t+cfgDd] = 1;
      if (prev >= 0 && cfgDd > 0 && prev + cfgDd >= t) dovEv[t] = 1;
      prev = t;
    end
    for (int i = 0; i < NG; i++) begin
      busyEnd = -1;
      for (int c = 0; c < MAXC; c++) begin
        if (encA[c]) begin
          if (c <= busyEnd) govEv[c][i] = 1;
          else begin
            busyEnd = c + cfgGd[i] + cfgGl;
            for (int k = c + cfgGd[i] + 1; k <= busyEnd; k++) if (k < MAXC) gateA[k] = 1;
          end
        end
      end
    end
    bc = 0; prevG = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (gateA[c] && !prevG) bc = 0;
      if (candA[c] && gateA[c] && (cfgBl == 0 || bc < cfgBl)) begin
        accA[c] = 1;
        bc++;
        for (int k = 1; k <= cfgDw; k++) if (c + k < MAXC) digA[c+k] = 1;
      end
      prevG = gateA[c];
    end
    cnt = '0; gov = '0; dov = 0;
    for (int c = 0; c < MAXC; c++) begin
      expCount[c] = cnt; expGov[c] = gov; expDov[c] = dov;
      if (clrA[c]) begin
        cnt = '0; gov = '0; dov = 0;
      end else begin
        if (accA[c]) cnt = cnt + 1;
        gov = gov | govEv[c];
        dov = dov | dovEv[c];
      end
    end
  endtask

  task automatic applyStimulus(input int c);
    enable          = (c >= cfgT0);
    encoder_trigger = encA[c];
    clear_status    = clrA[c];
  endtask

  task automatic checkAllZero(input string tag, input int c);
    checkOutput({tag, "_laser"}, c, 64'(laser_trigger), 64'(0));
    checkOutput({tag, "_dig"},   c, 64'(digitizer_trigger), 64'(0));
    checkOutput({tag, "_gate"},  c, 64'(gate_active), 64'(0));
    checkOutput({tag, "_count"}, c, 64'(dig_count), 64'(0));
    checkOutput({tag, "_gov"},   c, 64'(gate_overrun), 64'(0));
    checkOutput({tag, "_dov"},   c, 64'(delay_overrun), 64'(0));
  endtask

  task automatic runScenario();
    buildModel();
    period      = CNT_W'(cfgPeriodRaw);
    laser_width = CNT_W'(cfgLw);
    dig_delay   = CNT_W'(cfgDd);
    dig_width   = CNT_W'(cfgDw);
    gate_len    = CNT_W'(cfgGl);
    burst_limit = CNT_W'(cfgBl);
    for (int i = 0; i < NG; i++) gate_delay[i*CNT_W +: CNT_W] = CNT_W'(cfgGd[i]);
    reset = 1'b0; enable = 1'b0; encoder_trigger = 1'b0; clear_status = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("rst", -1);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      applyStimulus(c);
      @(negedge clk);
      checkOutput("laser", c, 64'(laser_trigger), 64'(laserA[c]));
      checkOutput("dig",   c, 64'(digitizer_trigger), 64'(digA[c]));
      checkOutput("gate",  c, 64'(gate_active), 64'(gateA[c]));
      checkOutput("count", c, 64'(dig_count), 64'(expCount[c]));
      checkOutput("gov",   c, 64'(gate_overrun), 64'(expGov[c]));
      checkOutput("dov",   c, 64'(delay_overrun), 64'(expDov[c]));
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkAllZero("async", NCYC);
    encoder_trigger = 1'b0;
    clear_status    = 1'b0;
    scen++;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; encoder_trigger = 1'b0; clear_status = 1'b0;
    period = '0; laser_width = '0; dig_delay = '0; dig_width = '0;
    gate_len = '0; burst_limit = '0; gate_delay = '0;

    // Windowed digitizer triggers, unlimited burst
    setConfig(10, 3, 2, 4, 30, 0, 3, 20, 20, 20, 20);
    clearStim();
    encA[40] = 1; encA[150] = 1;
    runScenario();

    // Burst limit 2, busy-channel overrun, then status clear
    setConfig(10, 3, 2, 4, 30, 2, 3, 20, 20, 20, 20);
    clearStim();
    encA[40] = 1; encA[45] = 1; encA[120] = 1; clrA[200] = 1;
    runScenario();

    // Delay longer than the period: no digitizer pulses, delay overrun
    setConfig(10, 3, 12, 4, 40, 0, 0, 5, 5, 5, 5);
    clearStim();
    encA[30] = 1;
    runScenario();

    // Degenerate period, laser continuously high, zero-width digitizer still counted
    setConfig(1, 5, 0, 0, 1, 0, 0, 0, 1, 3, 0);
    clearStim();
    encA[10] = 1; encA[11] = 1; encA[20] = 1; clrA[12] = 1;
    runScenario();

    for (int s = 0; s < 6; s++) begin
      int pr;
      pr = int'($urandom_range(0, 12));
      setConfig(pr, int'($urandom_range(0, ((pr < 2) ? 2 : pr) + 2)),
                int'($urandom_range(0, ((pr < 2) ? 2 : pr) + 3)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 25)),
                int'($urandom_range(0, 25)), int'($urandom_range(0, 25)),
                int'($urandom_range(0, 25)));
      clearStim();
      for (int c = 1; c < NCYC; c++) begin
        encA[c] = ($urandom_range(0, 24) == 0);
        clrA[c] = ($urandom_range(0, 99) == 0);
      end
      runScenario();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
